// File: rtl/ctrl_fsm_p.sv
// ctrl_fsm_p: Moore control unit for a small accumulator CPU.
// It sequences fetch and execute, drives bus select, register enables and the
// ALU operation, counts fetched instructions and flags undefined instructions.
module ctrl_fsm_p #(
    parameter int OP_W    = 5,
    parameter int NUM_GPR = 4,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    z,
    input  logic [OP_W+IDX_W-1:0]   instruction,
    output logic [2:0]              alu_op,
    output logic [3:0]              read_sel,
    output logic [6+NUM_GPR:0]      write_en,
    output logic [6+NUM_GPR:0]      inc_en,
    output logic [6+NUM_GPR:0]      clr_en,
    output logic                    busy,
    output logic                    end_process,
    output logic                    illegal_op,
    output logic [CNT_W-1:0]        instr_count
);

    // Enable-vector bit positions
    localparam int EN_PC  = 0;
    localparam int EN_AR  = 1;
    localparam int EN_IR  = 2;
    localparam int EN_AC  = 3;
    localparam int EN_R   = 4;
    localparam int EN_DM  = 5;
    localparam int EN_ALU = 6;
    localparam int EN_G0  = 7;

    // Bus source codes
    localparam logic [3:0] RS_PC = 4'd1;
    localparam logic [3:0] RS_AR = 4'd2;
    localparam logic [3:0] RS_IR = 4'd3;
    localparam logic [3:0] RS_AC = 4'd4;
    localparam logic [3:0] RS_R  = 4'd5;
    localparam logic [3:0] RS_DM = 4'd6;
    localparam logic [3:0] RS_IM = 4'd7;
    localparam logic [3:0] RS_G0 = 4'd8;

    // Opcode map
    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDAC   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LDIAC  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_STAC   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MVACR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MVACAR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MVACG  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MVGAC  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LSHIFT = OP_W'(11);
    localparam logic [OP_W-1:0] OP_INAC   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_CLAC   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_JPNZ   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_JPZ    = OP_W'(15);
    localparam logic [OP_W-1:0] OP_JMP    = OP_W'(16);
    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(31);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH1,
        S_FETCH2,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [OP_W-1:0]   op_q;
    logic [IDX_W-1:0]  idx_q;
    logic              gpr_ok;
    logic              exec_illegal;

    assign gpr_ok = (32'(idx_q) < 32'(NUM_GPR));

    // Classify the latched instruction as undefined (bad opcode or bad register index)
    always_comb begin
        exec_illegal = 1'b0;
        case (op_q)
            OP_NOP, OP_LDAC, OP_LDIAC, OP_STAC, OP_MVACR, OP_MVACAR,
            OP_ADD, OP_SUB, OP_MUL, OP_LSHIFT, OP_INAC, OP_CLAC,
            OP_JPNZ, OP_JPZ, OP_JMP, OP_HALT: exec_illegal = 1'b0;
            OP_MVACG, OP_MVGAC:               exec_illegal = !gpr_ok;
            default:                          exec_illegal = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; z only matters in EXEC1 of a conditional jump
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = start ? S_START : S_IDLE;
            S_START:  state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_EXEC1;
            S_EXEC1: begin
                state_next = S_FETCH1;
                if (exec_illegal) begin
                    state_next = S_HALT;
                end else begin
                    case (op_q)
                        OP_LDAC, OP_LDIAC, OP_JMP: state_next = S_EXEC2;
                        OP_JPNZ: state_next = z ? S_FETCH1 : S_EXEC2;
                        OP_JPZ:  state_next = z ? S_EXEC2 : S_FETCH1;
                        OP_HALT: state_next = S_HALT;
                        default: state_next = S_FETCH1;
                    endcase
                end
            end
            S_EXEC2:  state_next = S_FETCH1;
            S_HALT:   state_next = start ? S_START : S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Opcode/index latch loaded while the instruction register is stable in FETCH2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            idx_q <= '0;
        end else if (state == S_FETCH2) begin
            op_q  <= instruction[OP_W+IDX_W-1:IDX_W];
            idx_q <= instruction[IDX_W-1:0];
        end
    end

    // Fetched-instruction counter, wraps naturally and survives a restart from HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (state == S_FETCH2) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Sticky illegal flag: set when an undefined instruction halts, cleared by restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_op <= 1'b0;
        end else if (state == S_EXEC1 && exec_illegal) begin
            illegal_op <= 1'b1;
        end else if (state == S_HALT && start) begin
            illegal_op <= 1'b0;
        end
    end

    // Moore outputs from state and latched opcode/index
    always_comb begin
        alu_op      = 3'd0;
        read_sel    = 4'd0;
        write_en    = '0;
        inc_en      = '0;
        clr_en      = '0;
        busy        = 1'b0;
        end_process = 1'b0;
        case (state)
            S_START: begin
                busy          = 1'b1;
                clr_en[EN_PC] = 1'b1;
                clr_en[EN_AR] = 1'b1;
            end
            S_FETCH1: begin
                busy            = 1'b1;
                read_sel        = RS_IM;
                write_en[EN_IR] = 1'b1;
            end
            S_FETCH2: begin
                busy          = 1'b1;
                inc_en[EN_PC] = 1'b1;
            end
            S_EXEC1: begin
                busy = 1'b1;
                case (op_q)
                    OP_LDAC: begin
                        read_sel        = RS_AC;
                        write_en[EN_AR] = 1'b1;
                    end
                    OP_LDIAC: begin
                        read_sel        = RS_IR;
                        write_en[EN_AR] = 1'b1;
                    end
                    OP_STAC: begin
                        read_sel        = RS_AC;
                        write_en[EN_DM] = 1'b1;
                    end
                    OP_MVACR: begin
                        read_sel        = RS_AC;
                        write_en[EN_R]  = 1'b1;
                    end
                    OP_MVACAR: begin
                        read_sel        = RS_AC;
                        write_en[EN_AR] = 1'b1;
                    end
                    OP_MVACG: begin
                        if (gpr_ok) begin
                            read_sel = RS_AC;
                            for (int k = 0; k < NUM_GPR; k++) begin
                                if (32'(idx_q) == k) begin
                                    write_en[EN_G0+k] = 1'b1;
                                end
                            end
                        end
                    end
                    OP_MVGAC: begin
                        if (gpr_ok) begin
                            read_sel        = RS_G0 + 4'(idx_q);
                            write_en[EN_AC] = 1'b1;
                        end
                    end
                    OP_ADD: begin
                        alu_op           = 3'd1;
                        write_en[EN_ALU] = 1'b1;
                    end
                    OP_SUB: begin
                        alu_op           = 3'd2;
                        write_en[EN_ALU] = 1'b1;
                    end
                    OP_MUL: begin
                        alu_op           = 3'd3;
                        write_en[EN_ALU] = 1'b1;
                    end
                    OP_LSHIFT: begin
                        alu_op           = 3'd4;
                        write_en[EN_ALU] = 1'b1;
                    end
                    OP_INAC: inc_en[EN_AC] = 1'b1;
                    OP_CLAC: clr_en[EN_AC] = 1'b1;
                    default: ;
                endcase
            end
            S_EXEC2: begin
                busy = 1'b1;
                case (op_q)
                    OP_LDAC, OP_LDIAC: begin
                        read_sel        = RS_DM;
                        write_en[EN_AC] = 1'b1;
                    end
                    OP_JPNZ, OP_JPZ, OP_JMP: begin
                        read_sel        = RS_IR;
                        write_en[EN_PC] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT:  end_process = 1'b1;
            default: ;
        endcase
    end

    // RS_PC, RS_AR and RS_R are part of the bus map but never selected by this sequencer
    logic unused_codes;
    assign unused_codes = ^{RS_PC, RS_AR, RS_R};

endmodule

// File: tb/tb_ctrl_fsm_p.sv
// tb_ctrl_fsm_p: directed vector table, hand-written corner sequences and a
// randomized instruction stream checked against an instruction-level model.
module tb_ctrl_fsm_p;

    localparam int OP_W    = 5;
    localparam int NUM_GPR = 4;
    localparam int IDX_W   = 3;
    localparam int CNT_W   = 4;
    localparam int W       = 7 + NUM_GPR;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  z;
    logic [OP_W+IDX_W-1:0] instruction;
    logic [2:0]            alu_op;
    logic [3:0]            read_sel;
    logic [W-1:0]          write_en;
    logic [W-1:0]          inc_en;
    logic [W-1:0]          clr_en;
    logic                  busy;
    logic                  end_process;
    logic                  illegal_op;
    logic [CNT_W-1:0]      instr_count;

    ctrl_fsm_p #(
        .OP_W(OP_W), .NUM_GPR(NUM_GPR), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .z(z), .instruction(instruction),
        .alu_op(alu_op), .read_sel(read_sel), .write_en(write_en), .inc_en(inc_en),
        .clr_en(clr_en), .busy(busy), .end_process(end_process),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   alu;
        logic [3:0]   rsel;
        logic [W-1:0] we;
        logic [W-1:0] inc;
        logic [W-1:0] clr;
        logic         busy;
        logic         endp;
    } outs_t;

    typedef struct {
        logic [4:0] op;
        logic [2:0] idx;
        logic       zz;
        int         n_exec;
        outs_t      c1;
        outs_t      c2;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    start_cyc = 0;
    int    model_count = 0;
    vec_t  vecs[20];

    // Expected-output helpers expressed as register transfers
    function automatic outs_t busy_only();
        outs_t o;
        o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic outs_t xfer(input int src, input int dst);
        outs_t o;
        o = busy_only();
        o.rsel = 4'(src);
        o.we = W'(1) << dst;
        return o;
    endfunction

    function automatic outs_t alu_xfer(input int code);
        outs_t o;
        o = busy_only();
        o.alu = 3'(code);
        o.we = W'(1) << 6;
        return o;
    endfunction

    function automatic outs_t exp_idle();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t exp_halt();
        outs_t o;
        o = '0;
        o.endp = 1'b1;
        return o;
    endfunction

    function automatic outs_t exp_start();
        outs_t o;
        o = busy_only();
        o.clr = W'(3);
        return o;
    endfunction

    function automatic outs_t exp_fetch2();
        outs_t o;
        o = busy_only();
        o.inc = W'(1);
        return o;
    endfunction

    function automatic vec_t mkv(input logic [4:0] op, input logic [2:0] idx, input logic zz,
                                 input int n, input outs_t c1, input outs_t c2);
        vec_t v;
        v.op = op; v.idx = idx; v.zz = zz; v.n_exec = n; v.c1 = c1; v.c2 = c2;
        return v;
    endfunction

    // Instruction-level reference: what each instruction moves, and whether it halts
    function automatic void model_instr(input logic [4:0] op, input logic [2:0] idx, input logic zin,
                                        output outs_t c1, output outs_t c2, output int n_exec,
                                        output bit halts, output bit ill);
        bit jump;
        c1 = busy_only(); c2 = busy_only(); n_exec = 1; halts = 0; ill = 0; jump = 0;
        if (op == 5'd1 || op == 5'd2) begin
            c1 = xfer((op == 5'd1) ? 4 : 3, 1);
            c2 = xfer(6, 3);
            n_exec = 2;
        end else if (op == 5'd3) c1 = xfer(4, 5);
        else if (op == 5'd4) c1 = xfer(4, 4);
        else if (op == 5'd5) c1 = xfer(4, 1);
        else if (op == 5'd6 || op == 5'd7) begin
            if (int'(idx) < NUM_GPR) c1 = (op == 5'd6) ? xfer(4, 7 + int'(idx)) : xfer(8 + int'(idx), 3);
            else begin halts = 1; ill = 1; end
        end else if (op >= 5'd8 && op <= 5'd11) c1 = alu_xfer(int'(op) - 7);
        else if (op == 5'd12) c1.inc = W'(1) << 3;
        else if (op == 5'd13) c1.clr = W'(1) << 3;
        else if (op == 5'd14) jump = !zin;
        else if (op == 5'd15) jump = zin;
        else if (op == 5'd16) jump = 1;
        else if (op == 5'd31) halts = 1;
        else if (op != 5'd0) begin halts = 1; ill = 1; end
        if (jump) begin
            n_exec = 2;
            c2 = xfer(3, 0);
        end
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.alu = alu_op; o.rsel = read_sel; o.we = write_en; o.inc = inc_en;
        o.clr = clr_en; o.busy = busy; o.endp = end_process;
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got alu=%0d rsel=%0d we=%h inc=%h clr=%h busy=%b end=%b, expected alu=%0d rsel=%0d we=%h inc=%h clr=%h busy=%b end=%b",
                     name, act.alu, act.rsel, act.we, act.inc, act.clr, act.busy, act.endp,
                     exp.alu, exp.rsel, exp.we, exp.inc, exp.clr, exp.busy, exp.endp);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Run one instruction starting in FETCH1; leaves the DUT in FETCH1 or HALT
    task automatic applyStimulus(input string name, input logic [4:0] op, input logic [2:0] idx,
                                 input logic zval, input outs_t c1, input outs_t c2,
                                 input int n_exec, input bit halts, input bit ill);
        instruction = {op, idx};
        z = 1'($urandom); start = 1'($urandom);
        checkOutput({name, " fetch1"}, xfer(7, 2));
        step();
        z = 1'($urandom); start = 1'($urandom);
        checkOutput({name, " fetch2"}, exp_fetch2());
        model_count = (model_count + 1) % (1 << CNT_W);
        step();
        instruction = 8'($urandom);
        z = zval; start = 1'($urandom);
        checkOutput({name, " exec1"}, c1);
        checkValue({name, " instr_count"}, 32'(instr_count), 32'(model_count));
        if (n_exec == 2) begin
            step();
            z = 1'($urandom); start = 1'($urandom);
            checkOutput({name, " exec2"}, c2);
        end
        step();
        z = 1'($urandom);
        if (halts) begin
            start = 1'b0;
            checkOutput({name, " halt"}, exp_halt());
            checkValue({name, " illegal_op"}, 32'(illegal_op), 32'(ill));
        end else begin
            start = 1'($urandom);
        end
    endtask

    task automatic run_model(input string name, input logic [4:0] op, input logic [2:0] idx,
                             input logic zval, output bit halts);
        outs_t c1, c2;
        int    n;
        bit    ill;
        model_instr(op, idx, zval, c1, c2, n, halts, ill);
        applyStimulus(name, op, idx, zval, c1, c2, n, halts, ill);
    endtask

    // From IDLE or HALT: pulse start, check START, end in FETCH1
    task automatic restart(input string name);
        start = 1'b1;
        step();
        start_cyc = cyc;
        start = 1'b0;
        checkOutput({name, " start"}, exp_start());
        checkValue({name, " illegal cleared"}, 32'(illegal_op), 32'd0);
        checkValue({name, " count kept"}, 32'(instr_count), 32'(model_count));
        start = 1'($urandom);
        step();
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checkOutput({name, " outputs"}, exp_idle());
        checkValue({name, " instr_count"}, 32'(instr_count), 32'd0);
        checkValue({name, " illegal_op"}, 32'(illegal_op), 32'd0);
        model_count = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) begin
            step();
            checkOutput({name, " stays idle"}, exp_idle());
        end
    endtask

    initial begin
        bit h;
        rst_n = 1'b0; start = 1'b0; z = 1'b0; instruction = '0;

        vecs[0]  = mkv(5'd0,  3'd0, 1'b0, 1, busy_only(), busy_only());
        vecs[1]  = mkv(5'd1,  3'd0, 1'b0, 2, xfer(4, 1), xfer(6, 3));
        vecs[2]  = mkv(5'd2,  3'd1, 1'b1, 2, xfer(3, 1), xfer(6, 3));
        vecs[3]  = mkv(5'd3,  3'd0, 1'b0, 1, xfer(4, 5), busy_only());
        vecs[4]  = mkv(5'd4,  3'd0, 1'b0, 1, xfer(4, 4), busy_only());
        vecs[5]  = mkv(5'd5,  3'd0, 1'b0, 1, xfer(4, 1), busy_only());
        vecs[6]  = mkv(5'd6,  3'd2, 1'b0, 1, xfer(4, 9), busy_only());
        vecs[7]  = mkv(5'd6,  3'd0, 1'b0, 1, xfer(4, 7), busy_only());
        vecs[8]  = mkv(5'd7,  3'd3, 1'b0, 1, xfer(11, 3), busy_only());
        vecs[9]  = mkv(5'd8,  3'd0, 1'b0, 1, alu_xfer(1), busy_only());
        vecs[10] = mkv(5'd9,  3'd0, 1'b0, 1, alu_xfer(2), busy_only());
        vecs[11] = mkv(5'd10, 3'd0, 1'b0, 1, alu_xfer(3), busy_only());
        vecs[12] = mkv(5'd11, 3'd0, 1'b0, 1, alu_xfer(4), busy_only());
        vecs[13] = mkv(5'd12, 3'd0, 1'b0, 1, busy_only(), busy_only());
        vecs[13].c1.inc = W'(8);
        vecs[14] = mkv(5'd13, 3'd0, 1'b0, 1, busy_only(), busy_only());
        vecs[14].c1.clr = W'(8);
        vecs[15] = mkv(5'd14, 3'd0, 1'b0, 2, busy_only(), xfer(3, 0));
        vecs[16] = mkv(5'd14, 3'd0, 1'b1, 1, busy_only(), busy_only());
        vecs[17] = mkv(5'd15, 3'd0, 1'b1, 2, busy_only(), xfer(3, 0));
        vecs[18] = mkv(5'd15, 3'd0, 1'b0, 1, busy_only(), busy_only());
        vecs[19] = mkv(5'd16, 3'd0, 1'b1, 2, busy_only(), xfer(3, 0));

        do_reset("reset");

        // LDAC, ADD, HALT program
        restart("prog");
        applyStimulus("prog LDAC", 5'd1, 3'd0, 1'b0, xfer(4, 1), xfer(6, 3), 2, 0, 0);
        applyStimulus("prog ADD", 5'd8, 3'd0, 1'b0, alu_xfer(1), busy_only(), 1, 0, 0);
        applyStimulus("prog HALT", 5'd31, 3'd0, 1'b0, busy_only(), busy_only(), 1, 1, 0);
        checkValue("prog halt latency", 32'(cyc - start_cyc), 32'd11);
        checkValue("prog instr_count", 32'(instr_count), 32'd3);

        // Directed vector table
        restart("table");
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].idx, vecs[i].zz,
                          vecs[i].c1, vecs[i].c2, vecs[i].n_exec, 0, 0);
        end

        // Out-of-range register index halts with no write
        applyStimulus("MVACG idx5", 5'd6, 3'd5, 1'b0, busy_only(), busy_only(), 1, 1, 1);
        restart("after idx5");

        // Undefined opcode 20, then restart clears the flag
        applyStimulus("op20", 5'd20, 3'd0, 1'b0, busy_only(), busy_only(), 1, 1, 1);
        restart("after op20");

        // Reset pulsed in the middle of LDAC EXEC1
        instruction = {5'd1, 3'd0};
        step();
        step();
        checkOutput("midreset exec1", xfer(4, 1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset outputs", exp_idle());
        checkValue("midreset instr_count", 32'(instr_count), 32'd0);
        model_count = 0;
        #2 rst_n = 1'b1;
        start = 1'b0;
        step();
        checkOutput("midreset idle", exp_idle());
        restart("after midreset");

        // 17 NOPs wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            applyStimulus($sformatf("nop%0d", i), 5'd0, 3'd0, 1'b0, busy_only(), busy_only(), 1, 0, 0);
        end
        checkValue("wrap final count", 32'(instr_count), 32'd1);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            logic [4:0] op;
            logic [2:0] idx;
            if ($urandom_range(0, 99) < 80) op = 5'($urandom_range(0, 16));
            else op = 5'($urandom_range(17, 31));
            idx = 3'($urandom_range(0, 7));
            run_model($sformatf("rnd%0d op%0d", i, op), op, idx, 1'($urandom), h);
            if (h) restart($sformatf("rnd%0d restart", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm_p.md
CTRL_FSM_P -- requirements
Module: ctrl_fsm_p

Interface
REQ-001 SHALL have parameter OP_W, default 5, opcode width.
REQ-002 SHALL have parameter NUM_GPR, default 4, general registers G0..G(NUM_GPR-1), range 1..8.
REQ-003 SHALL have parameter IDX_W, default 3, register-index field width.
REQ-004 SHALL have parameter CNT_W, default 16, instruction-counter width.
REQ-005 SHALL have port clk, input, 1 bit; sole clock, all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit; begin program execution.
REQ-008 SHALL have port z, input, 1 bit; AC-zero flag from the datapath.
REQ-009 SHALL have port instruction, input, OP_W+IDX_W bits; IR contents as {opcode, idx}.
REQ-010 SHALL have port alu_op, output, 3 bits; 0 none, 1 add, 2 sub, 3 mul, 4 lshift.
REQ-011 SHALL have port read_sel, output, 4 bits; bus source: 0 none, 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 6 DM, 7 IM, 8+k Gk.
REQ-012 SHALL have ports write_en, inc_en and clr_en, outputs, 7+NUM_GPR bits each; bit positions 0 PC, 1 AR, 2 IR, 3 AC, 4 R, 5 DM, 6 ALU->AC, 7+k Gk.
REQ-013 SHALL have port busy, output, 1 bit; high from START through the last execute state.
REQ-014 SHALL have port end_process, output, 1 bit; high while in HALT.
REQ-015 SHALL have port illegal_op, output, 1 bit; sticky, set on an undefined opcode or idx>=NUM_GPR.
REQ-016 SHALL have port instr_count, output, CNT_W bits; number of instructions fetched.

Function
REQ-017 SHALL implement states IDLE, START, FETCH1, FETCH2, EXEC1, EXEC2, HALT.
REQ-018 SHALL derive all enable outputs and alu_op combinationally from the state and the latched opcode/idx (Moore); each output SHALL be all-zero in any state not listed for it.
REQ-019 SHALL advance IDLE->START only on start=1; START SHALL assert clr_en[PC] and clr_en[AR], then go to FETCH1.
REQ-020 FETCH1 SHALL assert read_sel=7 and write_en[IR], then go to FETCH2.
REQ-021 FETCH2 SHALL assert inc_en[PC], latch the opcode and idx from instruction, increment instr_count (wrapping at 2^CNT_W), then go to EXEC1.
REQ-022 The opcode map SHALL be: 0 NOP, 1 LDAC, 2 LDIAC, 3 STAC, 4 MVACR, 5 MVACAR, 6 MVACG, 7 MVGAC, 8 ADD, 9 SUB, 10 MUL, 11 LSHIFT, 12 INAC, 13 CLAC, 14 JPNZ, 15 JPZ, 16 JMP, 31 HALT; all other opcodes are illegal.
REQ-023 EXEC1 SHALL drive the following and then go to FETCH1 unless stated otherwise:
- NOP: no enables.
- LDAC: AC->AR; then EXEC2.
- LDIAC: IR->AR; then EXEC2.
- STAC: AC->DM.
- MVACR: AC->R.
- MVACAR: AC->AR.
- MVACG: AC->G[idx].
- MVGAC: G[idx]->AC.
- ADD/SUB/MUL/LSHIFT: write_en[6] with alu_op 1/2/3/4.
- INAC: inc_en[AC].
- CLAC: clr_en[AC].
REQ-024 EXEC2 for LDAC and LDIAC SHALL assert read_sel=6 and write_en[AC], then go to FETCH1.
REQ-025 In EXEC1, JPNZ with z=0, JPZ with z=1, or JMP SHALL go to EXEC2; otherwise the jump SHALL go to FETCH1 with no enables.
REQ-026 EXEC2 for a jump SHALL assert read_sel=3 and write_en[PC], then go to FETCH1.
REQ-027 z SHALL be sampled only in EXEC1 of a jump.
REQ-028 HALT opcode, illegal opcode, or idx>=NUM_GPR on MVACG/MVGAC SHALL go from EXEC1 to HALT; the illegal cases SHALL also set illegal_op and SHALL assert no enables.
REQ-029 HALT SHALL assert end_process=1 and busy=0; start=1 in HALT SHALL clear illegal_op, go to START, and leave instr_count unchanged.
REQ-030 start SHALL be ignored outside IDLE and HALT.
REQ-031 Instruction latency SHALL be 3 cycles for single-exec instructions, 4 for LDAC, LDIAC and taken jumps, and 3 for untaken jumps.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, all enables 0, alu_op=0, read_sel=0, busy=0, end_process=0, illegal_op=0, instr_count=0, including when reset is asserted mid-instruction.
REQ-033 After rst_n deasserts, the first transition SHALL occur only on a rising clk edge with start=1.

Verification
REQ-034 Reset then start, program LDAC, ADD, HALT: START shows clr_en[PC]=clr_en[AR]=1; ADD EXEC1 shows alu_op=1 and write_en[6]=1; end_process=1 after 3+4+3+1=11 cycles; instr_count=3.
REQ-035 JPNZ with z=0 takes 4 cycles with read_sel=3 and write_en[PC] in EXEC2; with z=1 it returns to FETCH1 after 3 cycles with no PC write.
REQ-036 NUM_GPR=4: MVACG idx=2 asserts write_en[9]=1 and read_sel=4; idx=5 sets illegal_op=1 and enters HALT with no write.
REQ-037 Opcode 20 causes illegal_op=1 and end_process=1; start=1 then clears illegal_op and the next cycle is START.
REQ-038 rst_n pulsed low during LDAC EXEC1: outputs are zero before the next clk edge, and the state is IDLE.
REQ-039 CNT_W=4 with 17 NOPs: instr_count wraps 15->0 and reads 1 after the 17th fetch.
